// File: rtl/div_unit_pkg.sv
// Shared constants for the multi-cycle integer divider: operand width and FSM encodings.
package div_unit_pkg;
  localparam int DIV_WIDTH = 32;

  localparam logic [1:0] DIV_IDLE = 2'd0;
  localparam logic [1:0] DIV_BUSY = 2'd1;
  localparam logic [1:0] DIV_DONE = 2'd2;
endpackage

// File: rtl/div_unit_step.sv
// One restoring-division iteration: shift {rem,quo} left, subtract divisor when it fits.
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem,
  input  logic [WIDTH-1:0] quo,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_next,
  output logic [WIDTH-1:0] quo_next
);
  // One extra bit: the shifted remainder can exceed WIDTH bits when divisor >= 2**(WIDTH-1).
  logic [WIDTH:0] rem_sh;
  logic [WIDTH:0] diff;
  logic           fits;

  always_comb begin
    rem_sh = {rem, quo[WIDTH-1]};
    diff   = rem_sh - {1'b0, divisor};
    fits   = ~diff[WIDTH];
    rem_next = fits ? diff[WIDTH-1:0] : rem_sh[WIDTH-1:0];
    quo_next = {quo[WIDTH-2:0], fits};
  end
endmodule

// File: rtl/div_unit.sv
// Radix-2 restoring DIV/DIVU unit: stall_div for WIDTH+1 cycles, result_valid/hi/lo at T+WIDTH+1.
// Optional DIV_EARLY_OUT_EN returns the divide-by-zero result straight from IDLE (result at T+1).
module div_unit
  import div_unit_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             signed_div,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cancel,
  output logic             stall_div,
  output logic             result_valid,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  logic [1:0]       state;
  logic [CNT_W-1:0] count;
  logic [WIDTH-1:0] rem, quo, dvs;
  logic             qsign, rsign, bzero;

  logic [WIDTH-1:0] abs_a, abs_b;
  logic [WIDTH-1:0] rem_next, quo_next;
  logic [WIDTH-1:0] rem_fix, quo_fix;
  logic             last;

  assign abs_a = (signed_div & a[WIDTH-1]) ? -a : a;
  assign abs_b = (signed_div & b[WIDTH-1]) ? -b : b;
  assign last  = (count == CNT_W'(WIDTH - 1));

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem      (rem),
    .quo      (quo),
    .divisor  (dvs),
    .rem_next (rem_next),
    .quo_next (quo_next)
  );

  // With a zero divisor the iterations leave rem=|a|, so restoring rsign reproduces a exactly.
  assign rem_fix = rsign ? -rem_next : rem_next;
  assign quo_fix = bzero ? '1 : (qsign ? -quo_next : quo_next);

  assign stall_div    = ~cancel & (((state == DIV_IDLE) & start) | (state == DIV_BUSY));
  assign result_valid = ~cancel & (state == DIV_DONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= DIV_IDLE;
      count <= '0;
      rem   <= '0;
      quo   <= '0;
      dvs   <= '0;
      qsign <= 1'b0;
      rsign <= 1'b0;
      bzero <= 1'b0;
      hi    <= '0;
      lo    <= '0;
    end else if (cancel) begin
      state <= DIV_IDLE;
      count <= '0;
    end else begin
      case (state)
        DIV_IDLE: begin
          if (start) begin
            qsign <= (a[WIDTH-1] ^ b[WIDTH-1]) & signed_div;
            rsign <= a[WIDTH-1] & signed_div;
            bzero <= (b == '0);
            rem   <= '0;
            quo   <= abs_a;
            dvs   <= abs_b;
            count <= '0;
`ifdef DIV_EARLY_OUT_EN
            if (b == '0) begin
              state <= DIV_DONE;
              hi    <= a;
              lo    <= '1;
            end else begin
              state <= DIV_BUSY;
            end
`else
            state <= DIV_BUSY;
`endif
          end
        end
        DIV_BUSY: begin
          rem   <= rem_next;
          quo   <= quo_next;
          count <= count + CNT_W'(1);
          if (last) begin
            state <= DIV_DONE;
            hi    <= rem_fix;
            lo    <= quo_fix;
          end
        end
        DIV_DONE: state <= DIV_IDLE;
        default:  state <= DIV_IDLE;
      endcase
    end
  end
endmodule
